// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: default sizes, pointer wrap helper and count type for sync_fifo.
package sync_fifo_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 5;
    localparam int DEF_PNTR_WIDTH = 3;

    typedef logic [DEF_PNTR_WIDTH:0] count_t;

    // Explicit compare so non-power-of-two depths wrap correctly.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: FIFO storage with one synchronous write port and one registered read port.
module sync_fifo_mem import sync_fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int PNTR_WIDTH = DEF_PNTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [PNTR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [PNTR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // Storage is deliberately not reset; only the output register is.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with fill count and almost flags.
// Define SYNC_FIFO_ERR_EN to enable sticky overflow/underflow flags (tied low otherwise).
module sync_fifo import sync_fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int PNTR_WIDTH = DEF_PNTR_WIDTH,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PNTR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int CW = PNTR_WIDTH + 1;

    logic [PNTR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic wr_ok, rd_ok;

    // Gating on the registered flags gives read priority when full and write priority when empty.
    assign wr_ok = we && !full;
    assign rd_ok = re && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= PNTR_WIDTH'(next_ptr(32'(wr_ptr), FIFO_DEPTH));
            if (rd_ok) rd_ptr <= PNTR_WIDTH'(next_ptr(32'(rd_ptr), FIFO_DEPTH));
            count <= (wr_ok && !rd_ok) ? count + CW'(1) :
                     (rd_ok && !wr_ok) ? count - CW'(1) : count;
        end
    end

    assign full         = count == CW'(FIFO_DEPTH);
    assign empty        = count == '0;
    assign almost_full  = count >= CW'(AF_LEVEL);
    assign almost_empty = count <= CW'(AE_LEVEL);

`ifdef SYNC_FIFO_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (we && full) overflow <= 1'b1;
            if (re && empty) underflow <= 1'b1;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    sync_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .PNTR_WIDTH(PNTR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_ok),
        .waddr(wr_ptr),
        .wdata(din),
        .re   (rd_ok),
        .raddr(rd_ptr),
        .rdata(dout)
    );
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: vector table, directed corner cases and random traffic against a queue model.
module tb_sync_fifo;
    localparam int DW = 8;
    localparam int DEPTH = 5;
    localparam int PW = 3;
`ifdef SYNC_FIFO_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, we, re;
    logic [DW-1:0] din, dout;
    logic full, empty, almost_full, almost_empty, overflow, underflow;
    logic [PW:0] count;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PNTR_WIDTH(PW),
        .AF_LEVEL(DEPTH - 1), .AE_LEVEL(1)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .re(re), .din(din), .dout(dout),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    int passed = 0;
    int total = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] dout_m;
    bit ovf_m, unf_m;

    typedef struct {
        bit we;
        bit re;
        logic [DW-1:0] din;
        int cnt;
        logic [DW-1:0] dout;
        bit full;
        bit empty;
        bit af;
        bit ae;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        q.delete();
        dout_m = '0;
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ":count"}, 32'(count), q.size());
        chk({tag, ":dout"}, 32'(dout), 32'(dout_m));
        chk({tag, ":full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ":empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ":almost_full"}, 32'(almost_full), 32'(q.size() >= DEPTH - 1));
        chk({tag, ":almost_empty"}, 32'(almost_empty), 32'(q.size() <= 1));
        chk({tag, ":overflow"}, 32'(overflow), 32'(ovf_m));
        chk({tag, ":underflow"}, 32'(underflow), 32'(unf_m));
    endtask

    // One clock: drive, advance the model from pre-edge occupancy, compare 1 time unit after the edge.
    task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input string tag);
        bit f, e;
        f = q.size() == DEPTH;
        e = q.size() == 0;
        we = w;
        re = r;
        din = d;
        @(posedge clk);
        if (ERR && w && f) ovf_m = 1'b1;
        if (ERR && r && e) unf_m = 1'b1;
        if (r && !e) dout_m = q.pop_front();
        if (w && !f) q.push_back(d);
        #1;
        we = 1'b0;
        re = 1'b0;
        check_model(tag);
    endtask

    initial begin
        logic [DW-1:0] held;
        rst = 1'b1; we = 1'b0; re = 1'b0; din = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset_held");
        rst = 1'b0;
        @(posedge clk); #1;
        check_model("reset_idle");

        vecs[0]  = '{1, 0, 8'h11, 1, 8'h00, 0, 0, 0, 1};
        vecs[1]  = '{1, 0, 8'h12, 2, 8'h00, 0, 0, 0, 0};
        vecs[2]  = '{1, 0, 8'h13, 3, 8'h00, 0, 0, 0, 0};
        vecs[3]  = '{1, 0, 8'h14, 4, 8'h00, 0, 0, 1, 0};
        vecs[4]  = '{1, 0, 8'h15, 5, 8'h00, 1, 0, 1, 0};
        vecs[5]  = '{1, 0, 8'h66, 5, 8'h00, 1, 0, 1, 0};
        vecs[6]  = '{0, 1, 8'h00, 4, 8'h11, 0, 0, 1, 0};
        vecs[7]  = '{0, 1, 8'h00, 3, 8'h12, 0, 0, 0, 0};
        vecs[8]  = '{0, 1, 8'h00, 2, 8'h13, 0, 0, 0, 0};
        vecs[9]  = '{0, 1, 8'h00, 1, 8'h14, 0, 0, 0, 1};
        vecs[10] = '{0, 1, 8'h00, 0, 8'h15, 0, 1, 0, 1};
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].we, vecs[i].re, vecs[i].din, "vec_model");
            chk("vec_count", 32'(count), vecs[i].cnt);
            chk("vec_dout", 32'(dout), 32'(vecs[i].dout));
            chk("vec_full", 32'(full), 32'(vecs[i].full));
            chk("vec_empty", 32'(empty), 32'(vecs[i].empty));
            chk("vec_almost_full", 32'(almost_full), 32'(vecs[i].af));
            chk("vec_almost_empty", 32'(almost_empty), 32'(vecs[i].ae));
        end
        chk("overflow_after_6th_write", 32'(overflow), 32'(ERR));

        for (int i = 0; i < 3; i++) step(1, 0, DW'(8'h21 + i), "wrap_w1");
        for (int i = 0; i < 3; i++) step(0, 1, '0, "wrap_r1");
        for (int i = 0; i < 5; i++) step(1, 0, DW'(8'h31 + i), "wrap_w2");
        for (int i = 0; i < 5; i++) step(0, 1, '0, "wrap_r2");
        chk("wrap_last_dout", 32'(dout), 32'h35);
        chk("wrap_count", 32'(count), 0);

        step(1, 0, 8'h41, "sim2_fill");
        step(1, 0, 8'h42, "sim2_fill");
        step(1, 1, 8'h43, "sim2");
        chk("sim2_count", 32'(count), 2);
        chk("sim2_dout", 32'(dout), 32'h41);
        for (int i = 0; i < 3; i++) step(1, 0, DW'(8'h51 + i), "simfull_fill");
        step(1, 1, 8'hEE, "simfull");
        chk("simfull_count", 32'(count), 4);
        chk("simfull_dout", 32'(dout), 32'h42);
        for (int i = 0; i < 4; i++) step(0, 1, '0, "simfull_drain");
        chk("simfull_drain_last", 32'(dout), 32'h53);
        held = dout;
        step(1, 1, 8'h77, "simempty");
        chk("simempty_count", 32'(count), 1);
        chk("simempty_dout_held", 32'(dout), 32'(held));
        step(0, 1, '0, "simempty_read");
        chk("simempty_read_dout", 32'(dout), 32'h77);

        step(0, 1, '0, "rd_empty");
        chk("rd_empty_dout_held", 32'(dout), 32'h77);
        chk("underflow_sticky", 32'(underflow), 32'(ERR));
        step(1, 0, 8'h01, "sticky_after_write");
        chk("underflow_stays", 32'(underflow), 32'(ERR));

        step(1, 0, 8'h61, "arst_fill");
        step(1, 0, 8'h62, "arst_fill");
        step(0, 0, '0, "arst_idle");
        rst = 1'b1;
        #2;
        model_reset();
        chk("arst_count_now", 32'(count), 0);
        chk("arst_empty_now", 32'(empty), 1);
        chk("arst_dout_now", 32'(dout), 0);
        chk("arst_underflow_now", 32'(underflow), 0);
        rst = 1'b0;
        step(1, 0, 8'hA5, "arst_w");
        step(0, 1, '0, "arst_r");
        chk("arst_a5", 32'(dout), 32'hA5);

        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 100) % 3;
            step(bias == 1 ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1)),
                 bias == 2 ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1)),
                 DW'($urandom), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
